ide_pio_cycle_timer: RTL and testbench

- Sits downstream of the IDE/Gayle address decoder.
- Consumes the decoded IDE-data and Gayle-register selects plus the 68000 strobes, and produces ATA PIO-timed _DIOR/_DIOW and the CPU _DTACK for all overridden (_OVR) cycles.
- Replaces the decoder's single-clock strobe qualification with programmable setup/active/recovery phases. IORDY wait handling is optional.

---
 rtl/ide_pkg.sv | 31 +++
 rtl/ide_phase_counter.sv | 28 ++
 rtl/ide_pio_cycle_timer.sv | 177 +++++++++++++++++
 tb/tb_ide_pio_cycle_timer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ide_pkg.sv
// ide_pkg: shared types and PIO mode 0 timing defaults for the IDE cycle timer.
//   state_t  : cycle-timer FSM encoding
//   cnt_t    : phase counter word (CNT_W bits)
//   ld_val() : counter load value for an N-cycle phase (N-1, floored at 0)
package ide_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        WAIT,
        ACK,
        RECOVER
    } state_t;

    // PIO mode 0 expressed in 7.09 MHz CPU clocks
    localparam int PIO0_SETUP     = 1;
    localparam int PIO0_ACTIVE    = 2;
    localparam int PIO0_RECOVER   = 2;
    localparam int PIO0_IORDY_TO  = 10;

    // A phase of n cycles loads n-1 and ends when the counter reads zero
    function automatic cnt_t ld_val(input int n);
        return (n > 0) ? cnt_t'(n - 1) : '0;
    endfunction

endpackage

// File: rtl/ide_phase_counter.sv
// ide_phase_counter: loadable saturating down-counter timing each cycle phase.
//   CLK      in  : CPU clock
//   _RESET   in  : asynchronous active-low reset (count = 0)
//   load     in  : load load_val this edge instead of counting
//   load_val in  : value to load
//   zero     out : count has reached zero (count holds there, never wraps)
module ide_phase_counter
    import ide_pkg::*;
(
    input  logic CLK,
    input  logic _RESET,
    input  logic load,
    input  cnt_t load_val,
    output logic zero
);

    cnt_t count;

    assign zero = (count == '0);

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET)
            count <= '0;
        else
            count <= load ? load_val : zero ? count : count - cnt_t'(1);
    end

endmodule

// File: rtl/ide_pio_cycle_timer.sv
// ide_pio_cycle_timer: ATA PIO setup/active/recovery timing of _DIOR/_DIOW and
// CPU _DTACK for cycles claimed by the IDE/Gayle address decoder.
//   CLK      in  : CPU clock (7.09 MHz)
//   _RESET   in  : asynchronous active-low reset
//   _AS      in  : 68000 address strobe, active low
//   R_W      in  : 68000 read/write, 1 = read
//   IDESEL   in  : decoded IDE data/register range (wins over REGSEL)
//   REGSEL   in  : decoded Gayle-register range, zero wait states
//   IORDY    in  : IDE IORDY, used only when IDE_IORDY_EN is defined
//   _DIOR    out : IDE read strobe, active low, registered
//   _DIOW    out : IDE write strobe, active low, registered
//   _DTACK   out : CPU data acknowledge, active low
//   DTACK_OE out : _DTACK pad enable
//   BUSY     out : FSM is not IDLE
// Build option: define IDE_IORDY_EN to add the IORDY WAIT phase with timeout.
module ide_pio_cycle_timer
    import ide_pkg::*;
#(
    parameter int SETUP_CYC     = PIO0_SETUP,
    parameter int ACTIVE_CYC    = PIO0_ACTIVE,
    parameter int RECOVER_CYC   = PIO0_RECOVER,
    parameter int IORDY_TIMEOUT = PIO0_IORDY_TO
)
(
    input  logic CLK,
    input  logic _RESET,
    input  logic _AS,
    input  logic R_W,
    input  logic IDESEL,
    input  logic REGSEL,
    input  logic IORDY,
    output logic _DIOR,
    output logic _DIOW,
    output logic _DTACK,
    output logic DTACK_OE,
    output logic BUSY
);

    // With no recovery time an IDE cycle returns straight to IDLE
    localparam state_t REC_ST = (RECOVER_CYC == 0) ? IDLE : RECOVER;

    state_t state, nxt, start_st;
    cnt_t   ld_v;
    logic   as_q, start, go, ld, zero, ide_q, rd_q, iordy_ok, strobe_nxt;

    // A cycle starts once _AS has been seen low on the previous edge and is
    // still low; the CPU holds it low while waiting, so a start arriving
    // during RECOVER simply stays visible until RECOVER ends.
    assign start    = as_q && !_AS && (IDESEL || REGSEL);
    assign start_st = IDESEL ? SETUP : ACK;
    assign BUSY     = (state != IDLE);

`ifdef IDE_IORDY_EN
    logic iordy_m, iordy_s;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            iordy_m <= 1'b0;
            iordy_s <= 1'b0;
        end else begin
            iordy_m <= IORDY;
            iordy_s <= iordy_m;
        end
    end

    assign iordy_ok = iordy_s;
`else
    logic unused_iordy;

    assign unused_iordy = IORDY;
    assign iordy_ok     = 1'b1;
`endif

    ide_phase_counter u_cnt (
        .CLK      (CLK),
        ._RESET   (_RESET),
        .load     (ld),
        .load_val (ld_v),
        .zero     (zero)
    );

    // _AS going high before ACK is an aborted cycle: drop the strobe and
    // recover without ever acknowledging.
    always_comb begin
        nxt  = state;
        go   = 1'b0;
        ld   = 1'b0;
        ld_v = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt  = start_st;
                    go   = 1'b1;
                    ld   = 1'b1;
                    ld_v = ld_val(SETUP_CYC);
                end
            end
            SETUP: begin
                if (_AS) begin
                    nxt  = REC_ST;
                    ld   = 1'b1;
                    ld_v = ld_val(RECOVER_CYC);
                end else if (zero) begin
                    nxt  = ACTIVE;
                    ld   = 1'b1;
                    ld_v = ld_val(ACTIVE_CYC);
                end
            end
            ACTIVE: begin
                if (_AS) begin
                    nxt  = REC_ST;
                    ld   = 1'b1;
                    ld_v = ld_val(RECOVER_CYC);
                end else if (zero) begin
                    nxt  = iordy_ok ? ACK : WAIT;
                    ld   = 1'b1;
                    ld_v = ld_val(IORDY_TIMEOUT);
                end
            end
            WAIT: begin
                if (_AS) begin
                    nxt  = REC_ST;
                    ld   = 1'b1;
                    ld_v = ld_val(RECOVER_CYC);
                end else if (iordy_ok || zero) begin
                    nxt = ACK;
                end
            end
            ACK: begin
                if (_AS) begin
                    nxt  = ide_q ? REC_ST : IDLE;
                    ld   = 1'b1;
                    ld_v = ld_val(RECOVER_CYC);
                end
            end
            RECOVER: begin
                if (zero) begin
                    nxt  = start ? start_st : IDLE;
                    go   = start;
                    ld   = start;
                    ld_v = ld_val(SETUP_CYC);
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign strobe_nxt = (nxt == ACTIVE) || (nxt == WAIT);

    // Outputs are registered from the next state so they switch on the same
    // edge as the state; _DTACK_OE lingers one cycle after ACK so the pad
    // drives _DTACK high before releasing it.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state    <= IDLE;
            as_q     <= 1'b0;
            ide_q    <= 1'b0;
            rd_q     <= 1'b0;
            _DIOR    <= 1'b1;
            _DIOW    <= 1'b1;
            _DTACK   <= 1'b1;
            DTACK_OE <= 1'b0;
        end else begin
            state    <= nxt;
            as_q     <= !_AS;
            if (go) begin
                ide_q <= IDESEL;
                rd_q  <= R_W;
            end
            _DIOR    <= !(strobe_nxt && rd_q);
            _DIOW    <= !(strobe_nxt && !rd_q);
            _DTACK   <= (nxt != ACK);
            DTACK_OE <= (nxt == ACK) || (state == ACK);
        end
    end

endmodule

// File: tb/tb_ide_pio_cycle_timer.sv
// tb_ide_pio_cycle_timer: directed-vector bench for ide_pio_cycle_timer with
// default timing (setup 1, active 2, recover 2, IORDY timeout 10).
// Histories record one bit per edge after the _AS sample edge (edge 1).
module tb_ide_pio_cycle_timer;

    logic clk = 1'b0;
    logic rst_n, as_n, r_w, idesel, regsel, iordy;
    logic dior_n, diow_n, dtack_n, dtack_oe, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] dior_h, diow_h, dtk_h, oe_h, busy_h;

    ide_pio_cycle_timer dut (
        .CLK      (clk),
        ._RESET   (rst_n),
        ._AS      (as_n),
        .R_W      (r_w),
        .IDESEL   (idesel),
        .REGSEL   (regsel),
        .IORDY    (iordy),
        ._DIOR    (dior_n),
        ._DIOW    (diow_n),
        ._DTACK   (dtack_n),
        .DTACK_OE (dtack_oe),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m(input int lo, input int hi);
        logic [31:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Drives one bus cycle starting mid-period; rel/fall2/rel2/irise name the
    // edge after which _AS rises, falls again, rises again, and IORDY rises.
    task automatic run(input logic rw, input logic ide, input logic rs, input int n,
                       input int rel, input int fall2, input int rel2, input int irise);
        dior_h = '0; diow_h = '0; dtk_h = '0; oe_h = '0; busy_h = '0;
        r_w = rw; idesel = ide; regsel = rs; as_n = 1'b0;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk); #1;
            dior_h[e] = !dior_n;
            diow_h[e] = !diow_n;
            dtk_h[e]  = !dtack_n;
            oe_h[e]   = dtack_oe;
            busy_h[e] = busy;
            if (e == rel || e == rel2) begin as_n = 1'b1; idesel = 1'b0; regsel = 1'b0; end
            if (e == fall2) begin as_n = 1'b0; idesel = ide; regsel = rs; end
            if (e == irise) iordy = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; as_n = 1'b1; r_w = 1'b1; idesel = 1'b0; regsel = 1'b0; iordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (dior_n !== 1'b1) begin miscompares++; $display("FAIL reset_dior got %b exp 1", dior_n); end
        vectors++; if (diow_n !== 1'b1) begin miscompares++; $display("FAIL reset_diow got %b exp 1", diow_n); end
        vectors++; if (dtack_n !== 1'b1) begin miscompares++; $display("FAIL reset_dtack got %b exp 1", dtack_n); end
        vectors++; if (dtack_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b exp 0", dtack_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ide_read;
        run(1'b1, 1'b1, 1'b0, 8, 5, 0, 0, 0);
        vectors++; if (dior_h !== m(3, 4)) begin miscompares++; $display("FAIL read_dior got %b exp %b", dior_h, m(3, 4)); end
        vectors++; if (diow_h !== '0) begin miscompares++; $display("FAIL read_diow got %b exp 0", diow_h); end
        vectors++; if (dtk_h !== m(5, 5)) begin miscompares++; $display("FAIL read_dtack got %b exp %b", dtk_h, m(5, 5)); end
        vectors++; if (oe_h !== m(5, 6)) begin miscompares++; $display("FAIL read_oe got %b exp %b", oe_h, m(5, 6)); end
        vectors++; if (busy_h !== m(2, 7)) begin miscompares++; $display("FAIL read_busy got %b exp %b", busy_h, m(2, 7)); end
    endtask

    task automatic test_ide_write;
        run(1'b0, 1'b1, 1'b0, 8, 5, 0, 0, 0);
        vectors++; if (diow_h !== m(3, 4)) begin miscompares++; $display("FAIL write_diow got %b exp %b", diow_h, m(3, 4)); end
        vectors++; if (dior_h !== '0) begin miscompares++; $display("FAIL write_dior got %b exp 0", dior_h); end
        vectors++; if (dtk_h !== m(5, 5)) begin miscompares++; $display("FAIL write_dtack got %b exp %b", dtk_h, m(5, 5)); end
    endtask

    task automatic test_regsel;
        run(1'b1, 1'b0, 1'b1, 5, 2, 0, 0, 0);
        vectors++; if (dtk_h !== m(2, 2)) begin miscompares++; $display("FAIL reg_dtack got %b exp %b", dtk_h, m(2, 2)); end
        vectors++; if (oe_h !== m(2, 3)) begin miscompares++; $display("FAIL reg_oe got %b exp %b", oe_h, m(2, 3)); end
        vectors++; if ((dior_h | diow_h) !== '0) begin miscompares++; $display("FAIL reg_strobe got %b exp 0", dior_h | diow_h); end
        vectors++; if (busy_h !== m(2, 2)) begin miscompares++; $display("FAIL reg_busy got %b exp %b", busy_h, m(2, 2)); end
    endtask

    task automatic test_back_to_back;
        run(1'b0, 1'b1, 1'b0, 14, 5, 6, 11, 0);
        vectors++; if (diow_h !== (m(3, 4) | m(9, 10))) begin miscompares++; $display("FAIL b2b_diow got %b exp %b", diow_h, m(3, 4) | m(9, 10)); end
        vectors++; if (dtk_h !== (m(5, 5) | m(11, 11))) begin miscompares++; $display("FAIL b2b_dtack got %b exp %b", dtk_h, m(5, 5) | m(11, 11)); end
        vectors++; if (busy_h !== m(2, 13)) begin miscompares++; $display("FAIL b2b_busy got %b exp %b", busy_h, m(2, 13)); end
    endtask

    task automatic test_abort_setup;
        run(1'b1, 1'b1, 1'b0, 6, 2, 0, 0, 0);
        vectors++; if ((dior_h | diow_h) !== '0) begin miscompares++; $display("FAIL abort_setup_strobe got %b exp 0", dior_h | diow_h); end
        vectors++; if (dtk_h !== '0) begin miscompares++; $display("FAIL abort_setup_dtack got %b exp 0", dtk_h); end
        vectors++; if (oe_h !== '0) begin miscompares++; $display("FAIL abort_setup_oe got %b exp 0", oe_h); end
        vectors++; if (busy_h !== m(2, 4)) begin miscompares++; $display("FAIL abort_setup_busy got %b exp %b", busy_h, m(2, 4)); end
    endtask

    task automatic test_abort_active;
        run(1'b1, 1'b1, 1'b0, 7, 3, 0, 0, 0);
        vectors++; if (dior_h !== m(3, 3)) begin miscompares++; $display("FAIL abort_active_dior got %b exp %b", dior_h, m(3, 3)); end
        vectors++; if (dtk_h !== '0) begin miscompares++; $display("FAIL abort_active_dtack got %b exp 0", dtk_h); end
        vectors++; if (busy_h !== m(2, 5)) begin miscompares++; $display("FAIL abort_active_busy got %b exp %b", busy_h, m(2, 5)); end
    endtask

    task automatic test_reset_mid_strobe;
        run(1'b1, 1'b1, 1'b0, 3, 0, 0, 0, 0);
        vectors++; if (dior_n !== 1'b0) begin miscompares++; $display("FAIL midrst_pre_dior got %b exp 0", dior_n); end
        rst_n = 1'b0;
        #1;
        vectors++; if (dior_n !== 1'b1) begin miscompares++; $display("FAIL midrst_dior got %b exp 1", dior_n); end
        vectors++; if (dtack_n !== 1'b1) begin miscompares++; $display("FAIL midrst_dtack got %b exp 1", dtack_n); end
        vectors++; if (dtack_oe !== 1'b0) begin miscompares++; $display("FAIL midrst_oe got %b exp 0", dtack_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b exp 0", busy); end
        as_n = 1'b1; idesel = 1'b0;
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({busy, dior_n} !== 2'b01) begin miscompares++; $display("FAIL midrst_after got %b exp 01", {busy, dior_n}); end
    endtask

`ifdef IDE_IORDY_EN
    task automatic test_iordy;
        iordy = 1'b0;
        run(1'b1, 1'b1, 1'b0, 13, 10, 0, 0, 7);
        vectors++; if (dior_h !== m(3, 9)) begin miscompares++; $display("FAIL iordy_wait_dior got %b exp %b", dior_h, m(3, 9)); end
        vectors++; if (dtk_h !== m(10, 10)) begin miscompares++; $display("FAIL iordy_wait_dtack got %b exp %b", dtk_h, m(10, 10)); end
        iordy = 1'b0;
        run(1'b1, 1'b1, 1'b0, 18, 15, 0, 0, 0);
        iordy = 1'b1;
        vectors++; if (dior_h !== m(3, 14)) begin miscompares++; $display("FAIL iordy_to_dior got %b exp %b", dior_h, m(3, 14)); end
        vectors++; if (dtk_h !== m(15, 15)) begin miscompares++; $display("FAIL iordy_to_dtack got %b exp %b", dtk_h, m(15, 15)); end
        repeat (4) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset;
        test_ide_read;
        test_ide_write;
        test_regsel;
        test_back_to_back;
        test_abort_setup;
        test_abort_active;
        test_reset_mid_strobe;
`ifdef IDE_IORDY_EN
        test_iordy;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
